// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, latches the
// instruction word and drives datapath controls, with illegal-opcode and memory-timeout traps.
module multicycle_control #(
  parameter int unsigned ALU_SEL_W      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic                 br_cond,
  output logic [31:0]          ir,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 instr_done,
  output logic                 illegal,
  output logic                 timeout,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic       dec_legal, dec_src, wait_expired;
  logic [3:0] dec_alu, f3_alu, alu_full;

  // Instruction decode from the latched IR
  always_comb begin
    is_r      = (ir_q[6:0] == OP_R);
    is_i      = (ir_q[6:0] == OP_I);
    is_load   = (ir_q[6:0] == OP_LOAD);
    is_store  = (ir_q[6:0] == OP_STORE);
    is_branch = (ir_q[6:0] == OP_BRANCH);
    is_jal    = (ir_q[6:0] == OP_JAL);
    is_jalr   = (ir_q[6:0] == OP_JALR);
    is_lui    = (ir_q[6:0] == OP_LUI);
    is_auipc  = (ir_q[6:0] == OP_AUIPC);

    case (ir_q[14:12])
      3'b000:  f3_alu = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ir_q[30] ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase

    dec_alu = ALU_ADD;
    if (is_r || is_i) begin
      dec_alu = f3_alu;
    end else if (is_branch) begin
      dec_alu = ALU_SUB;
    end
    dec_src = !(is_r || is_branch);

    dec_legal = is_r || is_i || is_load || is_store || is_branch ||
                is_jal || is_jalr || is_lui || is_auipc;
    if (is_r && (ir_q[31:25] != 7'b0000000) && (ir_q[31:25] != 7'b0100000)) begin
      dec_legal = 1'b0;
    end
    // The 3-bit ALU select has no encoding for the compare ops
    if ((ALU_SEL_W < 4) && (is_r || is_i) && (ir_q[14:13] == 2'b01)) begin
      dec_legal = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_START;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign wait_expired = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LIMIT);

  // The wait counter only holds a value while stalled in FETCH/MEM, so every
  // entry into either state starts it from zero.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    to_cnt_d  = '0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_full   = ALU_ADD;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_DECODE: begin
        alu_src  = dec_src;
        alu_full = dec_alu;
      end
      S_EXEC: begin
        alu_src  = dec_src;
        alu_full = dec_alu;
        if (is_branch) begin
          pc_we      = 1'b1;
          pc_src     = br_cond ? 2'd1 : 2'd0;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        alu_src  = dec_src;
        alu_full = dec_alu;
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready && is_store) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        alu_src    = dec_src;
        alu_full   = dec_alu;
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        pc_src     = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
      end
      default: ;
    endcase
  end

  assign alu_sel = alu_full[ALU_SEL_W-1:0];
  assign ir      = ir_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one task per scenario, inline expected values.
module tb_multicycle_control;

  logic        clk, rst_n, imem_ready, dmem_ready, br_cond;
  logic [31:0] imem_rdata;
  logic        imem_req, dmem_req, dmem_we, reg_write, mem_to_reg, alu_src;
  logic        pc_we, instr_done, illegal, timeout;
  logic [31:0] ir;
  logic [3:0]  alu_sel;
  logic [1:0]  pc_src;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  logic [3:0] wb_alu, ex_alu;
  logic       wb_src, wb_seen, trapped, ret, rw_seen, mem_we, ex_pcwe;
  logic [1:0] wb_pcsrc, ex_pcsrc;
  int         run_cycles;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        chk_src;
    logic        src;
    logic [1:0]  pcsrc;
  } dec_vec_t;

  dec_vec_t vecs [16] = '{
    '{32'h002081B3, 4'h2, 1'b1, 1'b0, 2'd0},  // add
    '{32'h40208033, 4'h6, 1'b1, 1'b0, 2'd0},  // sub
    '{32'h0020A033, 4'h8, 1'b1, 1'b0, 2'd0},  // slt
    '{32'h0020B033, 4'h9, 1'b1, 1'b0, 2'd0},  // sltu
    '{32'h4020D1B3, 4'h5, 1'b1, 1'b0, 2'd0},  // sra
    '{32'h4010D093, 4'h5, 1'b1, 1'b1, 2'd0},  // srai
    '{32'h0010D093, 4'h7, 1'b1, 1'b1, 2'd0},  // srli
    '{32'h0010E093, 4'h1, 1'b1, 1'b1, 2'd0},  // ori
    '{32'h0010F093, 4'h0, 1'b1, 1'b1, 2'd0},  // andi
    '{32'h0010C093, 4'h4, 1'b1, 1'b1, 2'd0},  // xori
    '{32'h00109093, 4'h3, 1'b1, 1'b1, 2'd0},  // slli
    '{32'h40008093, 4'h2, 1'b1, 1'b1, 2'd0},  // addi, imm bit 30 set
    '{32'h000010B7, 4'h2, 1'b0, 1'b0, 2'd0},  // lui
    '{32'h00001097, 4'h2, 1'b0, 1'b0, 2'd0},  // auipc
    '{32'h008000EF, 4'h2, 1'b0, 1'b0, 2'd1},  // jal
    '{32'h000080E7, 4'h2, 1'b0, 1'b0, 2'd2}   // jalr
  };

  multicycle_control #(.ALU_SEL_W(4), .TIMEOUT_CYCLES(16), .TO_CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .br_cond(br_cond), .ir(ir), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_sel(alu_sel), .pc_we(pc_we), .pc_src(pc_src),
    .instr_done(instr_done), .illegal(illegal), .timeout(timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    imem_ready = 1'b0; dmem_ready = 1'b0; br_cond = 1'b0; imem_rdata = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Runs one instruction with zero-wait memories starting from FETCH, capturing EXEC/WB outputs
  task automatic run_instr(input logic [31:0] instr);
    wb_seen = 0; trapped = 0; ret = 0; rw_seen = 0; mem_we = 0; ex_pcwe = 0;
    ex_alu = '0; ex_pcsrc = '0; wb_alu = '0; wb_src = 0; wb_pcsrc = '0;
    run_cycles = 0;
    for (int i = 0; i < 12 && !ret && !trapped; i++) begin
      imem_rdata = instr;
      imem_ready = (state == 3'd1);
      dmem_ready = (state == 3'd4);
      #1;
      if (state == 3'd3) begin ex_alu = alu_sel; ex_pcwe = pc_we; ex_pcsrc = pc_src; end
      if (state == 3'd5) begin wb_seen = 1; wb_alu = alu_sel; wb_src = alu_src; wb_pcsrc = pc_src; end
      if (state == 3'd6) trapped = 1;
      if (dmem_req) mem_we = dmem_we;
      if (reg_write) rw_seen = 1;
      if (instr_done) ret = 1;
      run_cycles++;
      cyc();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 0; dmem_ready = 0; br_cond = 0; imem_rdata = '0;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir); end
    checks++; if (illegal !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b%b exp=00", illegal, timeout); end
    checks++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || pc_we !== 1'b0 || reg_write !== 1'b0) begin failures++; $display("FAIL reset_enables got=%b%b%b%b exp=0000", imem_req, dmem_req, pc_we, reg_write); end
    checks++; if (alu_sel !== 4'h2) begin failures++; $display("FAIL reset_alu_sel got=%h exp=2", alu_sel); end
  endtask

  task automatic test_addi();
    apply_reset();
    cyc();
    imem_ready = 1; imem_rdata = 32'h00500093;
    #1;
    checks++; if (state !== 3'd1 || imem_req !== 1'b1) begin failures++; $display("FAIL addi_fetch got state=%0d req=%b exp 1/1", state, imem_req); end
    cyc();
    imem_ready = 0; imem_rdata = 32'hFFFFFFFF;
    #1;
    checks++; if (state !== 3'd2 || ir !== 32'h00500093) begin failures++; $display("FAIL addi_decode got state=%0d ir=%h exp 2/00500093", state, ir); end
    cyc(); #1;
    checks++; if (state !== 3'd3 || alu_sel !== 4'h2 || alu_src !== 1'b1) begin failures++; $display("FAIL addi_exec got state=%0d sel=%h src=%b exp 3/2/1", state, alu_sel, alu_src); end
    cyc(); #1;
    checks++; if (state !== 3'd5 || reg_write !== 1'b1 || mem_to_reg !== 1'b0 || pc_we !== 1'b1 || instr_done !== 1'b1) begin failures++; $display("FAIL addi_wb_ctrl got state=%0d rw=%b m2r=%b pcwe=%b done=%b exp 5/1/0/1/1", state, reg_write, mem_to_reg, pc_we, instr_done); end
    checks++; if (alu_src !== 1'b1 || alu_sel !== 4'h2 || pc_src !== 2'd0) begin failures++; $display("FAIL addi_wb_alu got src=%b sel=%h pcsrc=%0d exp 1/2/0", alu_src, alu_sel, pc_src); end
    cyc(); #1;
    checks++; if (state !== 3'd1 || instr_done !== 1'b0 || ir !== 32'h00500093) begin failures++; $display("FAIL addi_after got state=%0d done=%b ir=%h exp 1/0/00500093", state, instr_done, ir); end
  endtask

  task automatic test_load_wait();
    int n, req, waits;
    logic we_bad, m2r;
    n = 0; req = 0; waits = 0; we_bad = 0; m2r = 0; ret = 0;
    apply_reset();
    cyc();
    for (int i = 0; i < 20 && !ret; i++) begin
      imem_rdata = 32'h0000A103;
      imem_ready = (state == 3'd1);
      dmem_ready = (state == 3'd4) && (waits == 3);
      #1;
      if (dmem_req) begin req++; if (dmem_we !== 1'b0) we_bad = 1; end
      if (state == 3'd5 && mem_to_reg === 1'b1 && reg_write === 1'b1) m2r = 1;
      if (state == 3'd4 && !dmem_ready) waits++;
      if (instr_done) ret = 1;
      n++;
      cyc();
    end
    imem_ready = 0; dmem_ready = 0;
    checks++; if (n != 8 || ret !== 1'b1) begin failures++; $display("FAIL load_cycles got=%0d retired=%b exp=8/1", n, ret); end
    checks++; if (req != 4) begin failures++; $display("FAIL load_dmem_req_cycles got=%0d exp=4", req); end
    checks++; if (we_bad !== 1'b0) begin failures++; $display("FAIL load_dmem_we got=1 exp=0"); end
    checks++; if (m2r !== 1'b1) begin failures++; $display("FAIL load_wb_mem_to_reg got=%b exp=1", m2r); end
  endtask

  task automatic test_store();
    apply_reset();
    cyc();
    run_instr(32'h0020A023);
    checks++; if (run_cycles != 4 || ret !== 1'b1) begin failures++; $display("FAIL store_cycles got=%0d retired=%b exp=4/1", run_cycles, ret); end
    checks++; if (mem_we !== 1'b1 || rw_seen !== 1'b0 || wb_seen !== 1'b0) begin failures++; $display("FAIL store_ctrl got we=%b rw=%b wb=%b exp 1/0/0", mem_we, rw_seen, wb_seen); end
  endtask

  task automatic test_branch();
    logic cond;
    apply_reset();
    cyc();
    for (int k = 0; k < 2; k++) begin
      cond = (k == 0);
      br_cond = cond;
      run_instr(32'h00208463);
      checks++; if (run_cycles != 3 || ret !== 1'b1) begin failures++; $display("FAIL branch%0d_cycles got=%0d exp=3", k, run_cycles); end
      checks++; if (ex_alu !== 4'h6 || ex_pcwe !== 1'b1) begin failures++; $display("FAIL branch%0d_exec got sel=%h pcwe=%b exp 6/1", k, ex_alu, ex_pcwe); end
      checks++; if (ex_pcsrc !== {1'b0, cond}) begin failures++; $display("FAIL branch%0d_pc_src got=%0d exp=%0d", k, ex_pcsrc, cond); end
      checks++; if (rw_seen !== 1'b0 || state !== 3'd1) begin failures++; $display("FAIL branch%0d_after got rw=%b state=%0d exp 0/1", k, rw_seen, state); end
    end
    br_cond = 0;
  endtask

  task automatic test_alu_decode();
    apply_reset();
    cyc();
    foreach (vecs[j]) begin
      run_instr(vecs[j].instr);
      checks++; if (run_cycles != 4 || wb_seen !== 1'b1) begin failures++; $display("FAIL dec%0d_cycles got=%0d wb=%b exp=4/1", j, run_cycles, wb_seen); end
      checks++; if (wb_alu !== vecs[j].alu) begin failures++; $display("FAIL dec%0d_alu_sel got=%h exp=%h", j, wb_alu, vecs[j].alu); end
      checks++; if (wb_pcsrc !== vecs[j].pcsrc) begin failures++; $display("FAIL dec%0d_pc_src got=%0d exp=%0d", j, wb_pcsrc, vecs[j].pcsrc); end
      if (vecs[j].chk_src) begin
        checks++; if (wb_src !== vecs[j].src) begin failures++; $display("FAIL dec%0d_alu_src got=%b exp=%b", j, wb_src, vecs[j].src); end
      end
    end
  endtask

  task automatic test_illegal();
    logic bad;
    apply_reset();
    cyc();
    imem_ready = 1; imem_rdata = 32'h0000007F;
    cyc();
    imem_ready = 0;
    #1;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL illegal_decode got=%0d exp=2", state); end
    cyc(); #1;
    checks++; if (state !== 3'd6 || illegal !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL illegal_trap got state=%0d ill=%b req=%b exp 6/1/0", state, illegal, imem_req); end
    bad = 0;
    imem_ready = 1; dmem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      if (state !== 3'd6 || imem_req !== 1'b0 || pc_we !== 1'b0 || reg_write !== 1'b0 || illegal !== 1'b1) bad = 1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL illegal_hold got=1 exp=0"); end
    apply_reset();
    #1;
    checks++; if (illegal !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL illegal_cleared got ill=%b state=%0d exp 0/0", illegal, state); end
    cyc();
    run_instr(32'h02208033);
    checks++; if (trapped !== 1'b1 || ret !== 1'b0 || illegal !== 1'b1) begin failures++; $display("FAIL illegal_funct7 got trap=%b ret=%b ill=%b exp 1/0/1", trapped, ret, illegal); end
  endtask

  task automatic test_timeout();
    int fc, mc;
    logic tr;
    apply_reset();
    cyc();
    fc = 0; tr = 0;
    for (int i = 0; i < 40 && !tr; i++) begin
      #1;
      if (state == 3'd6) tr = 1;
      else begin
        if (state == 3'd1 && imem_req) fc++;
        cyc();
      end
    end
    checks++; if (tr !== 1'b1 || fc != 17) begin failures++; $display("FAIL fetch_timeout got trap=%b fetch_cycles=%0d exp 1/17", tr, fc); end
    checks++; if (timeout !== 1'b1 || imem_req !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL fetch_timeout_flags got to=%b req=%b ill=%b exp 1/0/0", timeout, imem_req, illegal); end

    apply_reset();
    cyc();
    for (int i = 0; i < 16; i++) cyc();
    imem_ready = 1; imem_rdata = 32'h00500093;
    #1;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL fetch_limit_wait got=%0d exp=1", state); end
    cyc();
    imem_ready = 0;
    #1;
    checks++; if (state !== 3'd2 || timeout !== 1'b0) begin failures++; $display("FAIL fetch_limit_ready got state=%0d to=%b exp 2/0", state, timeout); end
    cyc(); cyc(); #1;
    checks++; if (state !== 3'd5 || instr_done !== 1'b1) begin failures++; $display("FAIL fetch_limit_retire got state=%0d done=%b exp 5/1", state, instr_done); end

    apply_reset();
    cyc();
    imem_ready = 1; imem_rdata = 32'h0000A103;
    cyc();
    imem_ready = 0;
    mc = 0; tr = 0;
    for (int i = 0; i < 40 && !tr; i++) begin
      #1;
      if (state == 3'd6) tr = 1;
      else begin
        if (state == 3'd4 && dmem_req) mc++;
        cyc();
      end
    end
    checks++; if (tr !== 1'b1 || mc != 17 || timeout !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL mem_timeout got trap=%b mem_cycles=%0d to=%b req=%b exp 1/17/1/0", tr, mc, timeout, dmem_req); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cyc();
    imem_ready = 1; imem_rdata = 32'h0000A103;
    cyc();
    imem_ready = 0;
    cyc(); cyc(); #1;
    checks++; if (state !== 3'd4 || dmem_req !== 1'b1) begin failures++; $display("FAIL midreset_pre got state=%0d req=%b exp 4/1", state, dmem_req); end
    rst_n = 0;
    #1;
    checks++; if (dmem_req !== 1'b0 || state !== 3'd0 || ir !== 32'h0) begin failures++; $display("FAIL midreset_async got req=%b state=%0d ir=%h exp 0/0/0", dmem_req, state, ir); end
    checks++; if (pc_we !== 1'b0 || reg_write !== 1'b0) begin failures++; $display("FAIL midreset_enables got pcwe=%b rw=%b exp 0/0", pc_we, reg_write); end
    cyc();
    dmem_ready = 1;
    #1;
    checks++; if (state !== 3'd0 || dmem_req !== 1'b0) begin failures++; $display("FAIL midreset_held got state=%0d req=%b exp 0/0", state, dmem_req); end
    rst_n = 1; dmem_ready = 0;
    cyc(); #1;
    checks++; if (state !== 3'd1 || imem_req !== 1'b1) begin failures++; $display("FAIL midreset_release got state=%0d req=%b exp 1/1", state, imem_req); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_branch();
    test_alu_decode();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
